// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared types for the hazard/control pipeline: control bundle, ARM condition codes,
// forwarding selects and flag bit positions.
package hazard_ctrl_pipe_pkg;

  localparam int RA_W     = 4;
  localparam int ALUCTL_W = 4;
  localparam int NFLAGS   = 4;
  localparam int PC_REG   = 15;

  // Flag register order is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [1:0]          flag_w;   // [1] writes N,Z  [0] writes C,V
    logic                pcs;
    logic                reg_w;
    logic                mem_w;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                branch;
    logic                bl;
  } ctrl_t;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Decoder/datapath-facing signal bundle of hazard_ctrl_pipe; master drives the D-stage
// side, slave is the control unit itself.
interface hazard_ctrl_pipe_if #(parameter int RA_W = 4);
  import hazard_ctrl_pipe_pkg::*;

  logic              valid_d;
  ctrl_t             ctrl_d;
  logic [3:0]        cond_d;
  logic [RA_W-1:0]   ra1_d;
  logic [RA_W-1:0]   ra2_d;
  logic [RA_W-1:0]   wa_d;
  logic [NFLAGS-1:0] alu_flags_e;

  ctrl_t             ctrl_e;
  logic              pc_src_w;
  logic              reg_write_w;
  logic              mem_write_m;
  logic              mem_to_reg_w;
  logic              branch_taken_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic [NFLAGS-1:0] flags;

  modport master (
    output valid_d, ctrl_d, cond_d, ra1_d, ra2_d, wa_d, alu_flags_e,
    input  ctrl_e, pc_src_w, reg_write_w, mem_write_m, mem_to_reg_w, branch_taken_e,
           stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, flags
  );

  modport slave (
    input  valid_d, ctrl_d, cond_d, ra1_d, ra2_d, wa_d, alu_flags_e,
    output ctrl_e, pc_src_w, reg_write_w, mem_write_m, mem_to_reg_w, branch_taken_e,
           stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, flags
  );

endinterface

// File: rtl/hazard_ctrl_pipe_cond_check.sv
// ARM condition-field evaluation against the {N,Z,C,V} flag register.
module hazard_ctrl_pipe_cond_check
  import hazard_ctrl_pipe_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [NFLAGS-1:0] flags,
  output logic              cond_ok
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves cond_ok unassigned (no latch).
    cond_ok = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ok = z;
      NE: cond_ok = ~z;
      CS: cond_ok = c;
      CC: cond_ok = ~c;
      MI: cond_ok = n;
      PL: cond_ok = ~n;
      VS: cond_ok = v;
      VC: cond_ok = ~v;
      HI: cond_ok = c & ~z;
      LS: cond_ok = ~c | z;
      GE: cond_ok = (n == v);
      LT: cond_ok = (n != v);
      GT: cond_ok = ~z & (n == v);
      LE: cond_ok = z | (n != v);
      AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;   // NV never executes
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipelined control + hazard unit for the 5-stage ARM-subset core (D->E->M->W).
// Define FORWARD_EN for operand forwarding; otherwise RAW hazards on E/M results stall D.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int RA_W   = hazard_ctrl_pipe_pkg::RA_W,
  parameter int PC_REG = hazard_ctrl_pipe_pkg::PC_REG
) (
  input logic               clk,
  input logic               reset_n,
  hazard_ctrl_pipe_if.slave io
);

`ifdef FORWARD_EN
  localparam bit FORWARD = 1'b1;
`else
  localparam bit FORWARD = 1'b0;
`endif

  localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

  // E stage
  logic              valid_e;
  ctrl_t             ctrl_e_q;
  logic [3:0]        cond_e_q;
  logic [RA_W-1:0]   ra1_e, ra2_e, wa_e;
  // M stage (writes already gated by condition)
  logic              reg_write_m, mem_write_m, mem_to_reg_m, pcs_m;
  logic [RA_W-1:0]   wa_m;
  // W stage
  logic              reg_write_w, pc_src_w, mem_to_reg_w;
  logic [RA_W-1:0]   wa_w;

  logic [NFLAGS-1:0] flags_q;
  logic              cond_ok_e, exec_e;
  logic              ldr_stall, dep_stall, hold, pc_wr_pend, branch_taken;
  logic              flush_e_int;
  fwd_sel_e          fwd_a, fwd_b;

  hazard_ctrl_pipe_cond_check u_cond (
    .cond    (cond_e_q),
    .flags   (flags_q),
    .cond_ok (cond_ok_e)
  );

  assign exec_e       = valid_e & cond_ok_e;
  assign branch_taken = exec_e & ctrl_e_q.branch;
  assign ldr_stall    = valid_e & ctrl_e_q.mem_to_reg & (wa_e != PC_IDX) &
                        ((wa_e == io.ra1_d) | (wa_e == io.ra2_d));
  assign pc_wr_pend   = (io.valid_d & io.ctrl_d.pcs) | (exec_e & ctrl_e_q.pcs) | pcs_m;

  always_comb begin
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    dep_stall = 1'b0;
    if (FORWARD) begin
      if (reg_write_m && wa_m == ra1_e && ra1_e != PC_IDX)      fwd_a = FWD_M;
      else if (reg_write_w && wa_w == ra1_e && ra1_e != PC_IDX) fwd_a = FWD_W;
      if (reg_write_m && wa_m == ra2_e && ra2_e != PC_IDX)      fwd_b = FWD_M;
      else if (reg_write_w && wa_w == ra2_e && ra2_e != PC_IDX) fwd_b = FWD_W;
    end else begin
      // W is covered by the write-first register file, so only E and M producers block D
      dep_stall = ((io.ra1_d != PC_IDX) &&
                   ((exec_e && ctrl_e_q.reg_w && wa_e == io.ra1_d) ||
                    (reg_write_m && wa_m == io.ra1_d))) ||
                  ((io.ra2_d != PC_IDX) &&
                   ((exec_e && ctrl_e_q.reg_w && wa_e == io.ra2_d) ||
                    (reg_write_m && wa_m == io.ra2_d)));
    end
  end

  assign hold        = ldr_stall | dep_stall;
  assign flush_e_int = hold | branch_taken;

  // Reset forces every combinational output low as well as the registers
  assign io.stall_f        = reset_n & (hold | pc_wr_pend);
  assign io.stall_d        = reset_n & hold & ~branch_taken;
  assign io.flush_d        = reset_n & (pc_wr_pend | pc_src_w | branch_taken);
  assign io.flush_e        = reset_n & flush_e_int;
  assign io.branch_taken_e = reset_n & branch_taken;
  assign io.fwd_a_e        = reset_n ? fwd_a : FWD_RF;
  assign io.fwd_b_e        = reset_n ? fwd_b : FWD_RF;

  assign io.ctrl_e       = ctrl_e_q;
  assign io.flags        = flags_q;
  assign io.mem_write_m  = mem_write_m;
  assign io.reg_write_w  = reg_write_w;
  assign io.pc_src_w     = pc_src_w;
  assign io.mem_to_reg_w = mem_to_reg_w;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e  <= 1'b0;
      ctrl_e_q <= '0;
      cond_e_q <= '0;
      ra1_e    <= '0;
      ra2_e    <= '0;
      wa_e     <= '0;
    end else if (flush_e_int || !io.valid_d) begin
      valid_e  <= 1'b0;
      ctrl_e_q <= '0;
      cond_e_q <= '0;
      ra1_e    <= '0;
      ra2_e    <= '0;
      wa_e     <= '0;
    end else begin
      valid_e  <= 1'b1;
      ctrl_e_q <= io.ctrl_d;
      cond_e_q <= io.cond_d;
      ra1_e    <= io.ra1_d;
      ra2_e    <= io.ra2_d;
      wa_e     <= io.wa_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pcs_m        <= 1'b0;
      wa_m         <= '0;
      reg_write_w  <= 1'b0;
      pc_src_w     <= 1'b0;
      mem_to_reg_w <= 1'b0;
      wa_w         <= '0;
    end else begin
      reg_write_m  <= exec_e & ctrl_e_q.reg_w;
      mem_write_m  <= exec_e & ctrl_e_q.mem_w;
      mem_to_reg_m <= ctrl_e_q.mem_to_reg;
      pcs_m        <= exec_e & ctrl_e_q.pcs;
      wa_m         <= wa_e;
      reg_write_w  <= reg_write_m;
      pc_src_w     <= pcs_m;
      mem_to_reg_w <= mem_to_reg_m;
      wa_w         <= wa_m;
    end
  end

  // A failed-condition instruction never touches the flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else begin
      if (exec_e && ctrl_e_q.flag_w[1])
        flags_q[FLAG_N:FLAG_Z] <= io.alu_flags_e[FLAG_N:FLAG_Z];
      if (exec_e && ctrl_e_q.flag_w[0])
        flags_q[FLAG_C:FLAG_V] <= io.alu_flags_e[FLAG_C:FLAG_V];
    end
  end

endmodule
